id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage RV32 core. Registers the decoded instruction fields and operands that the EX stage consumes: ALUOp, fun7 (I[30]), fun3 and rs1/rs2/imm data, which feed the ALU control decoder and the ALU.
- Owns load-use hazard detection: it stalls PC and IF/ID and inserts a bubble into EX.
- Owns branch-flush squashing of the instruction entering EX.
- Keeps saturating bubble and flush counters for performance debug.

---
 rtl/core_pkg.sv | 24 ++
 rtl/id_ex_stage_if.sv | 63 ++++++
 rtl/id_ex_stage_load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core definitions: widths, ALUOp encodings and the ID control bundle.
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_W    = 5;

  // Main-control ALUOp encodings seen by the ALU control decoder.
  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } id_ctrl_t;

  // A bubble carries no side effects: every control bit is zero.
  localparam id_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side fields entering the stage and their registered EX-side copies.
interface id_ex_stage_if
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_fun7;
  logic [2:0]       id_fun3;
  logic [1:0]       id_alu_op;
  logic             id_alu_src;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_reg_write;
  logic             id_mem_to_reg;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_fun7;
  logic [2:0]       ex_fun3;
  logic [1:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;

  // Decode stage drives the id_* side and observes ex_*.
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_uses_rs2,
           id_rd, id_fun7, id_fun3, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_fun7,
           ex_fun3, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg
  );

  // The pipeline register consumes id_* and produces ex_*.
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_uses_rs2,
           id_rd, id_fun7, id_fun3, id_alu_op, id_alu_src, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_fun7,
           ex_fun3, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard: a load in EX whose rd is read by the valid instruction in ID.
module load_use_detect
  import core_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             hazard
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
             ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch-flush squash and perf counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  id_ex_stage_if.slave     bus,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic             ex_valid_q;
  logic [XLEN-1:0]  ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [REG_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic             ex_fun7_q;
  logic [2:0]       ex_fun3_q;
  id_ctrl_t         ex_ctrl_q;
  logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;
  id_ctrl_t         id_ctrl;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rd       (ex_rd_q),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs2 (bus.id_uses_rs2),
    .hazard      (hazard)
  );

  // Gather ID control bits; an invalid ID slot contributes no side effects.
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    if (bus.id_valid) begin
      id_ctrl = '{alu_op:     bus.id_alu_op,
                  alu_src:    bus.id_alu_src,
                  mem_read:   bus.id_mem_read,
                  mem_write:  bus.id_mem_write,
                  reg_write:  bus.id_reg_write,
                  mem_to_reg: bus.id_mem_to_reg};
    end
    // A flush replaces the held instruction, so no stall is needed alongside it.
    stall = hazard & ~flush & ~reset;
  end

  // Pipeline register: reset > flush bubble > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_fun7_q     <= 1'b0;
      ex_fun3_q     <= '0;
      ex_ctrl_q     <= CTRL_BUBBLE;
      bubble_cnt_q  <= '0;
      flush_cnt_q   <= '0;
    end else begin
      // Data fields always follow ID; only ex_valid and control decide if they matter.
      ex_pc_q       <= bus.id_pc;
      ex_rs1_data_q <= bus.id_rs1_data;
      ex_rs2_data_q <= bus.id_rs2_data;
      ex_imm_q      <= bus.id_imm;
      ex_rs1_q      <= bus.id_rs1;
      ex_rs2_q      <= bus.id_rs2;
      ex_rd_q       <= bus.id_rd;
      ex_fun7_q     <= bus.id_fun7;
      ex_fun3_q     <= bus.id_fun3;
      if (flush) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= CTRL_BUBBLE;
        if (bus.id_valid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (hazard) begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= CTRL_BUBBLE;
        if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end else begin
        ex_valid_q <= bus.id_valid;
        ex_ctrl_q  <= id_ctrl;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_rs1_data   = ex_rs1_data_q;
  assign bus.ex_rs2_data   = ex_rs2_data_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_rs1        = ex_rs1_q;
  assign bus.ex_rs2        = ex_rs2_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_fun7       = ex_fun7_q;
  assign bus.ex_fun3       = ex_fun3_q;
  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign bubble_count      = bubble_cnt_q;
  assign flush_count       = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; counters built 2 bits wide to reach saturation quickly.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             stall;
  logic [CNT_W-1:0] bubble_count, flush_count;
  int               tests = 0;
  int               fails = 0;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .stall        (stall),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  localparam id_ctrl_t CTRL_R  = '{alu_op: ALUOP_R, alu_src: 1'b0, mem_read: 1'b0,
                                   mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b0};
  localparam id_ctrl_t CTRL_LW = '{alu_op: ALUOP_LDST, alu_src: 1'b1, mem_read: 1'b1,
                                   mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b1};
  localparam id_ctrl_t CTRL_I  = '{alu_op: ALUOP_R, alu_src: 1'b1, mem_read: 1'b0,
                                   mem_write: 1'b0, reg_write: 1'b1, mem_to_reg: 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] rs1d,
                       input logic [31:0] rs2d, input logic [31:0] imm, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic uses2, input logic [4:0] rd,
                       input logic fun7, input logic [2:0] fun3, input id_ctrl_t c);
    bus.id_valid      = valid;
    bus.id_pc         = pc;
    bus.id_rs1_data   = rs1d;
    bus.id_rs2_data   = rs2d;
    bus.id_imm        = imm;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_uses_rs2   = uses2;
    bus.id_rd         = rd;
    bus.id_fun7       = fun7;
    bus.id_fun3       = fun3;
    bus.id_alu_op     = c.alu_op;
    bus.id_alu_src    = c.alu_src;
    bus.id_mem_read   = c.mem_read;
    bus.id_mem_write  = c.mem_write;
    bus.id_reg_write  = c.reg_write;
    bus.id_mem_to_reg = c.mem_to_reg;
  endtask

  function automatic id_ctrl_t ex_ctrl();
    return '{alu_op: bus.ex_alu_op, alu_src: bus.ex_alu_src, mem_read: bus.ex_mem_read,
             mem_write: bus.ex_mem_write, reg_write: bus.ex_reg_write,
             mem_to_reg: bus.ex_mem_to_reg};
  endfunction

  initial begin
    // 1: reset held two cycles with random ID inputs
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
          1'b1, 5'($urandom), 1'b1, 3'($urandom), CTRL_LW);
    tick();
    tick();
    check("rst_stall", stall, 0);
    check("rst_valid", bus.ex_valid, 0);
    check("rst_pc", bus.ex_pc, 0);
    check("rst_rd", bus.ex_rd, 0);
    check("rst_rs1data", bus.ex_rs1_data, 0);
    check("rst_ctrl", ex_ctrl(), 0);
    check("rst_bubble", bubble_count, 0);
    check("rst_flush", flush_count, 0);
    reset = 1'b0;

    // 2: ADD x3, x1, x2 passes through unchanged
    drive(1'b1, 32'h100, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 3'b000, CTRL_R);
    #1 check("add_stall", stall, 0);
    tick();
    check("add_valid", bus.ex_valid, 1);
    check("add_pc", bus.ex_pc, 32'h100);
    check("add_rs1data", bus.ex_rs1_data, 5);
    check("add_rs2data", bus.ex_rs2_data, 7);
    check("add_rd", bus.ex_rd, 3);
    check("add_fun3", bus.ex_fun3, 0);
    check("add_fun7", bus.ex_fun7, 0);
    check("add_ctrl", ex_ctrl(), CTRL_R);

    // 3: lw x5 then add x6, x5, x1 -> one bubble
    drive(1'b1, 32'h104, 32'h40, 32'h0, 32'd8, 5'd2, 5'd0, 1'b0, 5'd5, 1'b0, 3'b010, CTRL_LW);
    #1 check("lw_nostall", stall, 0);
    tick();
    check("lw_ctrl", ex_ctrl(), CTRL_LW);
    drive(1'b1, 32'h108, 32'd9, 32'd4, 32'h0, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 3'b000, CTRL_R);
    #1 check("lu_stall", stall, 1);
    tick();
    check("lu_bub_valid", bus.ex_valid, 0);
    check("lu_bub_ctrl", ex_ctrl(), 0);
    check("lu_bubble_cnt", bubble_count, 1);
    check("lu_replay_stall", stall, 0);
    tick();
    check("lu_add_valid", bus.ex_valid, 1);
    check("lu_add_rd", bus.ex_rd, 6);
    check("lu_add_pc", bus.ex_pc, 32'h108);
    check("lu_bubble_hold", bubble_count, 1);

    // 4a: lw x0 followed by a reader of x0
    drive(1'b1, 32'h10c, 32'h0, 32'h0, 32'd4, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 3'b010, CTRL_LW);
    tick();
    drive(1'b1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 3'b000, CTRL_R);
    #1 check("x0_stall", stall, 0);
    tick();
    check("x0_valid", bus.ex_valid, 1);
    // 4b: lw x5 then I-type whose rs2 field aliases x5 but is unused
    drive(1'b1, 32'h114, 32'h40, 32'h0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd5, 1'b0, 3'b010, CTRL_LW);
    tick();
    drive(1'b1, 32'h118, 32'd1, 32'd0, 32'd3, 5'd1, 5'd5, 1'b0, 5'd8, 1'b0, 3'b000, CTRL_I);
    #1 check("itype_stall", stall, 0);
    tick();
    check("itype_rd", bus.ex_rd, 8);
    check("itype_ctrl", ex_ctrl(), CTRL_I);

    // invalid ID slot: fields captured, control forced to zero
    drive(1'b0, 32'h11c, 32'd1, 32'd2, 32'd3, 5'd9, 5'd10, 1'b1, 5'd11, 1'b1, 3'b101, CTRL_LW);
    tick();
    check("inv_valid", bus.ex_valid, 0);
    check("inv_ctrl", ex_ctrl(), 0);

    // 5: flush concurrent with a load-use hazard
    drive(1'b1, 32'h120, 32'h40, 32'h0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd5, 1'b0, 3'b010, CTRL_LW);
    tick();
    drive(1'b1, 32'h124, 32'd9, 32'd4, 32'h0, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0, 3'b000, CTRL_R);
    flush = 1'b1;
    #1 check("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    check("fl_valid", bus.ex_valid, 0);
    check("fl_ctrl", ex_ctrl(), 0);
    check("fl_flush_cnt", flush_count, 1);
    check("fl_bubble_cnt", bubble_count, 1);

    // reset mid-stall: stall drops at once, next edge clears the stage
    drive(1'b1, 32'h128, 32'h40, 32'h0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd5, 1'b0, 3'b010, CTRL_LW);
    tick();
    drive(1'b1, 32'h12c, 32'd9, 32'd4, 32'h0, 5'd1, 5'd5, 1'b1, 5'd6, 1'b0, 3'b000, CTRL_R);
    #1 check("rs_pre_stall", stall, 1);
    reset = 1'b1;
    #1 check("rs_stall", stall, 0);
    tick();
    reset = 1'b0;
    check("rs_valid", bus.ex_valid, 0);
    check("rs_bubble_cnt", bubble_count, 0);
    check("rs_flush_cnt", flush_count, 0);

    // 6: five load-use pairs saturate the 2-bit bubble counter at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 8), 32'h40, 32'h0, 32'd0, 5'd2, 5'd0, 1'b0, 5'd5, 1'b0,
            3'b010, CTRL_LW);
      tick();
      drive(1'b1, 32'h204 + 32'(i * 8), 32'd1, 32'd2, 32'h0, 5'd5, 5'd1, 1'b1, 5'd6, 1'b0,
            3'b000, CTRL_R);
      #1 check($sformatf("sat_stall%0d", i), stall, 1);
      tick();
      check($sformatf("sat_cnt%0d", i), bubble_count, (i < 3) ? i + 1 : 3);
      tick();
      check($sformatf("sat_add%0d", i), bus.ex_valid, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
